simon_key_schedule_serial_param: RTL and testbench

//  Parametrised bit-serial SIMON key schedule covering all ten SIMON block/key sizes.

---
 rtl/simon_pkg.sv | 40 ++++
 rtl/simon_bit_shiftreg.sv | 20 ++
 rtl/simon_key_schedule_serial_param.sv | 139 +++++++++++++
 tb/tb_simon_key_schedule_serial_param.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared definitions for the bit-serial SIMON key schedule: z sequences, FSM states
// and the set of legal (word, key-word, round) configurations.
package simon_pkg;

  // Written so that the leftmost character is z[0].
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

  typedef enum logic [1:0] {ST_LOAD, ST_READY, ST_RUN, ST_DONE} state_t;

  function automatic logic z_lookup(input logic [2:0] sel, input logic [5:0] idx);
    logic [61:0] z;
    case (sel)
      3'd0:    z = Z0;
      3'd1:    z = Z1;
      3'd2:    z = Z2;
      3'd3:    z = Z3;
      default: z = Z4;
    endcase
    return z[6'd61 - idx];
  endfunction

  function automatic logic legal_cfg(input int unsigned n, input int unsigned m,
                                     input int unsigned t);
    return (n == 16 && m == 4 && t == 32) ||
           (n == 24 && m == 3 && t == 36) ||
           (n == 24 && m == 4 && t == 36) ||
           (n == 32 && m == 3 && t == 42) ||
           (n == 32 && m == 4 && t == 44) ||
           (n == 48 && m == 2 && t == 52) ||
           (n == 48 && m == 3 && t == 54) ||
           (n == 64 && m == 2 && t == 68) ||
           (n == 64 && m == 3 && t == 69) ||
           (n == 64 && m == 4 && t == 72);
  endfunction

endpackage

// File: rtl/simon_bit_shiftreg.sv
// Enabled serial shift register holding one key word; shifts toward bit 0 and exposes
// the five lowest bits for the round-key update taps.
module simon_bit_shiftreg #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       en,
  input  logic       din,
  output logic [4:0] taps
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (en) sr <= {din, sr[DEPTH-1:1]};
  end

  assign taps = sr[4:0];

endmodule

// File: rtl/simon_key_schedule_serial_param.sv
// Bit-serial SIMON key schedule: loads KEY_M key words serially, then streams round keys
// LSB first under a valid/ready handshake while generating k(i+m) alongside k(i).
module simon_key_schedule_serial_param
  import simon_pkg::*;
#(
  parameter int unsigned WORD_N = 16,
  parameter int unsigned KEY_M  = 4,
  parameter int unsigned ROUNDS = 32,
  parameter int unsigned Z_SEL  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_valid,
  input  logic       load_bit,
  output logic       load_ready,
  input  logic       start,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_bit,
  output logic [5:0] bit_idx,
  output logic [6:0] round_idx,
  output logic       round_odd,
  output logic       done
);

  if (!legal_cfg(WORD_N, KEY_M, ROUNDS) || Z_SEL > 4) begin : g_bad_cfg
    $error("simon_key_schedule_serial_param: unsupported configuration");
  end

  localparam logic [7:0] LOAD_LAST  = 8'(WORD_N * KEY_M - 1);
  localparam logic [5:0] LAST_BIT   = 6'(WORD_N - 1);
  localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);
  localparam logic [5:0] WRAP3      = 6'(WORD_N - 3);
  localparam logic [5:0] WRAP4      = 6'(WORD_N - 4);

  state_t state, state_nx;
  logic [7:0] load_cnt;
  logic [5:0] z_idx;
  logic [3:0] side;
  logic [KEY_M-1:0][4:0] taps;
  logic load_acc, xfer, shift_en, chain_in, new_bit;
  logic a3, a4, b0, b1;
  logic [5:0] wrap_off;
  logic unused_taps;

  always_comb begin
    state_nx   = state;
    load_ready = 1'b0;
    key_valid  = 1'b0;
    done       = 1'b0;
    case (state)
      ST_LOAD: begin
        load_ready = 1'b1;
        if (load_valid && load_cnt == LOAD_LAST) state_nx = ST_READY;
      end
      ST_READY: if (start) state_nx = ST_RUN;
      ST_RUN: begin
        key_valid = 1'b1;
        if (key_ready && bit_idx == LAST_BIT && round_idx == LAST_ROUND) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_LOAD;
      end
      default: state_nx = ST_LOAD;
    endcase
  end

  assign load_acc  = load_valid && load_ready;
  assign xfer      = key_ready && key_valid;
  assign shift_en  = load_acc || xfer;
  assign chain_in  = load_ready ? load_bit : new_bit;
  assign key_bit   = taps[0][0];
  assign round_odd = round_idx[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_LOAD;
      load_cnt  <= '0;
      bit_idx   <= '0;
      round_idx <= '0;
      z_idx     <= '0;
    end else begin
      state <= state_nx;
      if (load_acc) load_cnt <= (load_cnt == LOAD_LAST) ? '0 : load_cnt + 8'd1;
      if (state == ST_DONE) begin
        round_idx <= '0;
        z_idx     <= '0;
      end else if (xfer) begin
        if (bit_idx == LAST_BIT) begin
          bit_idx   <= '0;
          round_idx <= round_idx + 7'd1;
          z_idx     <= (z_idx == 6'd61) ? '0 : z_idx + 6'd1;
        end else begin
          bit_idx <= bit_idx + 6'd1;
        end
      end
    end
  end

  // Low bits of k(i+m-1) leave the word before the top bits need them; keep a copy.
  always_ff @(posedge clk) begin
    if (xfer && bit_idx < 6'd4) side[bit_idx[1:0]] <= taps[KEY_M-1][0];
  end

  // Word q's LSB is k(i+q)[j]; tmp[j] = a[j+3]^a[j+4]^b[j]^b[j+1] (indices mod WORD_N).
  always_comb begin
    wrap_off = bit_idx - WRAP4;
    a4 = (bit_idx < WRAP4) ? taps[KEY_M-1][4] : side[wrap_off[1:0]];
    a3 = (bit_idx < WRAP3) ? taps[KEY_M-1][3] : side[wrap_off[1:0] - 2'd1];
    b0 = 1'b0;
    b1 = 1'b0;
    if (KEY_M == 4) begin
      b0 = taps[1][0];
      // k(i+1)[0] has already shifted down into word 0, one place above its LSB.
      b1 = (bit_idx == LAST_BIT) ? taps[0][1] : taps[1][1];
    end
    new_bit = taps[0][0] ^ a3 ^ a4 ^ b0 ^ b1 ^ (bit_idx >= 6'd2) ^
              ((bit_idx == 6'd0) & z_lookup(3'(Z_SEL), z_idx));
  end

  for (genvar q = 0; q < KEY_M; q++) begin : g_word
    logic din;
    if (q == KEY_M - 1) begin : g_top
      assign din = chain_in;
    end else begin : g_mid
      assign din = taps[q+1][0];
    end
    simon_bit_shiftreg #(.DEPTH(WORD_N)) u_sr (
      .clk  (clk),
      .en   (shift_en),
      .din  (din),
      .taps (taps[q])
    );
  end

  assign unused_taps = ^taps;

endmodule

// File: tb/tb_simon_key_schedule_serial_param.sv
// Bench for the serial SIMON key schedule: three configurations checked against a
// word-level key-expansion model, plus stall, reset-abort and start corner cases.
module tb_simon_key_schedule_serial_param;

  localparam int CFG_N [3] = '{16, 64, 24};
  localparam int CFG_M [3] = '{4, 2, 3};
  localparam int CFG_T [3] = '{32, 68, 36};
  localparam int CFG_Z [3] = '{0, 2, 0};

  typedef struct {
    int unsigned rnd;
    logic [15:0] word;
  } kvec_t;

  logic clk = 1'b0;
  logic [2:0] rst_v, load_valid_v, load_bit_v, start_v, key_ready_v;
  logic [2:0] load_ready_v, key_valid_v, key_bit_v, round_odd_v, done_v;
  logic [2:0][5:0] bit_idx_v;
  logic [2:0][6:0] round_idx_v;

  logic [63:0] rk  [3][72];
  logic [63:0] cap [72];
  int unsigned total = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  simon_key_schedule_serial_param #(.WORD_N(16), .KEY_M(4), .ROUNDS(32), .Z_SEL(0)) dut0 (
    .clk(clk), .rst(rst_v[0]), .load_valid(load_valid_v[0]), .load_bit(load_bit_v[0]),
    .load_ready(load_ready_v[0]), .start(start_v[0]), .key_valid(key_valid_v[0]),
    .key_ready(key_ready_v[0]), .key_bit(key_bit_v[0]), .bit_idx(bit_idx_v[0]),
    .round_idx(round_idx_v[0]), .round_odd(round_odd_v[0]), .done(done_v[0]));

  simon_key_schedule_serial_param #(.WORD_N(64), .KEY_M(2), .ROUNDS(68), .Z_SEL(2)) dut1 (
    .clk(clk), .rst(rst_v[1]), .load_valid(load_valid_v[1]), .load_bit(load_bit_v[1]),
    .load_ready(load_ready_v[1]), .start(start_v[1]), .key_valid(key_valid_v[1]),
    .key_ready(key_ready_v[1]), .key_bit(key_bit_v[1]), .bit_idx(bit_idx_v[1]),
    .round_idx(round_idx_v[1]), .round_odd(round_odd_v[1]), .done(done_v[1]));

  simon_key_schedule_serial_param #(.WORD_N(24), .KEY_M(3), .ROUNDS(36), .Z_SEL(0)) dut2 (
    .clk(clk), .rst(rst_v[2]), .load_valid(load_valid_v[2]), .load_bit(load_bit_v[2]),
    .load_ready(load_ready_v[2]), .start(start_v[2]), .key_valid(key_valid_v[2]),
    .key_ready(key_ready_v[2]), .key_bit(key_bit_v[2]), .bit_idx(bit_idx_v[2]),
    .round_idx(round_idx_v[2]), .round_odd(round_odd_v[2]), .done(done_v[2]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [61:0] z_const(input int sel);
    case (sel)
      0:       return 62'b11111010001001010110000111001101111101000100101011000011100110;
      1:       return 62'b10001110111110010011000010110101000111011111001001100001011010;
      2:       return 62'b10101111011100000011010010011000101000010001111110010110110011;
      3:       return 62'b11011011101011000110010111100000010010001010011100110100001111;
      default: return 62'b11010001111001101011011000100000010111000011001010010011101111;
    endcase
  endfunction

  function automatic logic [63:0] word_mask(input int n);
    return (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] x, input int r, input int n);
    return ((x >> r) | (x << (n - r))) & word_mask(n);
  endfunction

  // Whole-word SIMON key expansion.
  task automatic build_model(input int d, input logic [63:0] kw [4]);
    int n = CFG_N[d];
    int m = CFG_M[d];
    int t = CFG_T[d];
    logic [63:0] mask = word_mask(n);
    logic [63:0] tmp;
    logic [61:0] zs = z_const(CFG_Z[d]);
    for (int i = 0; i < m; i++) rk[d][i] = kw[i] & mask;
    for (int i = 0; i + m < t; i++) begin
      tmp = ror(rk[d][i+m-1], 3, n);
      if (m == 4) tmp ^= rk[d][i+1];
      tmp ^= ror(tmp, 1, n);
      rk[d][i+m] = rk[d][i] ^ tmp ^ (mask & ~64'd3) ^ 64'(zs[61 - (i % 62)]);
    end
  endtask

  task automatic load_key(input int d, input logic [63:0] kw [4], input int stall_pct,
                          input bit poke_start);
    int n = CFG_N[d];
    int m = CFG_M[d];
    int idx = 0;
    int budget = 10 * n * m + 50;
    bit acc;
    while (idx < n * m && budget > 0) begin
      check($sformatf("load_state d%0d i%0d", d, idx),
            64'({load_ready_v[d], key_valid_v[d], done_v[d]}), 64'(3'b100));
      load_valid_v[d] = (int'($urandom_range(99)) >= stall_pct);
      load_bit_v[d]   = kw[idx / n][idx % n];
      if (poke_start) start_v[d] = 1'($urandom_range(1));
      acc = load_valid_v[d] && load_ready_v[d];
      @(negedge clk);
      if (acc) idx++;
      budget--;
    end
    load_valid_v[d] = 1'b0;
    start_v[d]      = 1'b0;
    check($sformatf("load_count d%0d", d), 64'(idx), 64'(n * m));
    check($sformatf("ready_state d%0d", d),
          64'({load_ready_v[d], key_valid_v[d], done_v[d]}), 64'(3'b000));
  endtask

  task automatic run_stream(input int d, input int stall_pct, input bit poke_start,
                            input int abort_r, input int abort_b);
    int n = CFG_N[d];
    int t = CFG_T[d];
    int r = 0;
    int b = 0;
    bit go;
    logic [15:0] act, exp;
    start_v[d]     = 1'b1;
    key_ready_v[d] = 1'b0;
    @(negedge clk);
    start_v[d] = 1'b0;
    while (r < t) begin
      act = {key_valid_v[d], key_bit_v[d], bit_idx_v[d], round_idx_v[d], round_odd_v[d]};
      exp = {1'b1, rk[d][r][b], 6'(b), 7'(r), 1'(r & 1)};
      check($sformatf("stream d%0d r%0d b%0d", d, r, b), 64'(act), 64'(exp));
      if (d == 0) cap[r][b] = key_bit_v[0];
      go = (int'($urandom_range(99)) >= stall_pct);
      key_ready_v[d] = go;
      if (poke_start) start_v[d] = 1'($urandom_range(1));
      if (r == abort_r && b == abort_b) begin
        rst_v[d] = 1'b1;
        @(negedge clk);
        rst_v[d]       = 1'b0;
        key_ready_v[d] = 1'b0;
        start_v[d]     = 1'b0;
        check($sformatf("abort_state d%0d", d),
              64'({key_valid_v[d], load_ready_v[d], done_v[d], bit_idx_v[d], round_idx_v[d]}),
              64'({3'b010, 6'd0, 7'd0}));
        return;
      end
      @(negedge clk);
      if (go) begin
        b++;
        if (b == n) begin
          b = 0;
          r++;
        end
      end
    end
    key_ready_v[d] = 1'b0;
    start_v[d]     = 1'b0;
    check($sformatf("done_pulse d%0d", d),
          64'({done_v[d], key_valid_v[d], load_ready_v[d]}), 64'(3'b100));
    @(negedge clk);
    check($sformatf("back_to_load d%0d", d),
          64'({done_v[d], key_valid_v[d], load_ready_v[d], bit_idx_v[d], round_idx_v[d]}),
          64'({3'b001, 6'd0, 7'd0}));
  endtask

  initial begin
    logic [63:0] kw [4];
    kvec_t vec [5];

    vec[0] = '{0, 16'h0100};
    vec[1] = '{1, 16'h0908};
    vec[2] = '{2, 16'h1110};
    vec[3] = '{3, 16'h1918};
    vec[4] = '{4, 16'h71C3};

    rst_v        = '1;
    load_valid_v = '0;
    load_bit_v   = '0;
    start_v      = '0;
    key_ready_v  = '0;
    repeat (3) @(negedge clk);
    rst_v = '0;
    for (int d = 0; d < 3; d++)
      check($sformatf("reset d%0d", d),
            64'({load_ready_v[d], key_valid_v[d], done_v[d], bit_idx_v[d], round_idx_v[d]}),
            64'({3'b100, 6'd0, 7'd0}));

    // Published 32/64 key, no stalls; first five round keys against known values.
    kw = '{64'h0100, 64'h0908, 64'h1110, 64'h1918};
    build_model(0, kw);
    load_key(0, kw, 0, 1'b0);
    run_stream(0, 0, 1'b0, -1, -1);
    for (int i = 0; i < 5; i++)
      check($sformatf("known_rk%0d", vec[i].rnd), 64'(cap[vec[i].rnd][15:0]), 64'(vec[i].word));

    // 128/128 and 48/72 with random keys.
    for (int d = 1; d < 3; d++) begin
      for (int w = 0; w < 4; w++) kw[w] = {$urandom, $urandom};
      build_model(d, kw);
      load_key(d, kw, 0, 1'b0);
      run_stream(d, 0, 1'b0, -1, -1);
    end

    // 30% stalls on both handshakes, with start toggling outside READY.
    for (int w = 0; w < 4; w++) kw[w] = {$urandom, $urandom};
    build_model(0, kw);
    load_key(0, kw, 30, 1'b1);
    run_stream(0, 30, 1'b1, -1, -1);

    // Reset at round 5 bit 7, then a fresh key.
    load_key(0, kw, 0, 1'b0);
    run_stream(0, 0, 1'b0, 5, 7);
    for (int w = 0; w < 4; w++) kw[w] = {$urandom, $urandom};
    build_model(0, kw);
    load_key(0, kw, 10, 1'b0);
    run_stream(0, 20, 1'b0, -1, -1);

    // start together with rst in READY: reset wins.
    load_key(0, kw, 0, 1'b0);
    rst_v[0]   = 1'b1;
    start_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0]   = 1'b0;
    start_v[0] = 1'b0;
    check("start_rst_same_cycle", 64'({load_ready_v[0], key_valid_v[0], done_v[0]}), 64'(3'b100));
    @(negedge clk);
    check("start_rst_stays_load", 64'({load_ready_v[0], key_valid_v[0], round_idx_v[0]}),
          64'({2'b10, 7'd0}));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
